// File: rtl/bpsk_symbol_mapper_pkg.sv
// Shared definitions for the BPSK transmit mapper and the receive-side sign slicer.
// Both ends import the bit/sign convention from here so they cannot drift apart.
package bpsk_symbol_mapper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Bit value that is sent as -1.0; the slicer reads a set sign bit back as this value.
  localparam logic BIT_FOR_NEG = 1'b1;

  // Widest symbol supported; narrower symbols take the low bits of these.
  localparam int unsigned SYM_MAX_W   = 64;
  localparam logic [SYM_MAX_W-1:0] SYM_POS_MAX = 64'd1;
  localparam logic [SYM_MAX_W-1:0] SYM_NEG_MAX = '1;

  function automatic logic bit_is_negative(input logic tx_bit);
    return tx_bit == BIT_FOR_NEG;
  endfunction

  function automatic logic slice_sign(input logic sign_bit);
    return sign_bit ? BIT_FOR_NEG : ~BIT_FOR_NEG;
  endfunction

endpackage

// File: rtl/bpsk_symbol_mapper_bit_map.sv
// Combinational bit -> two's-complement +/-1.0 symbol; forces zero when not valid.
module bpsk_bit_map
  import bpsk_symbol_mapper_pkg::*;
#(
  parameter int unsigned DATA_OUT_WIDTH = 4
) (
  input  logic                      tx_bit,
  input  logic                      valid,
  output logic [DATA_OUT_WIDTH-1:0] sym_out
);

  localparam logic [DATA_OUT_WIDTH-1:0] SYM_POS = SYM_POS_MAX[DATA_OUT_WIDTH-1:0];
  localparam logic [DATA_OUT_WIDTH-1:0] SYM_NEG = SYM_NEG_MAX[DATA_OUT_WIDTH-1:0];

  always_comb begin
    sym_out = '0;
    if (valid) begin
      sym_out = bit_is_negative(tx_bit) ? SYM_NEG : SYM_POS;
    end
  end

endmodule

// File: rtl/bpsk_symbol_mapper.sv
// Serializes parallel words into BPSK symbols, each held for SPS handshaked samples.
// o_data_ready is combinational from i_sym_ready so back-to-back words stream with no gap.
module bpsk_symbol_mapper
  import bpsk_symbol_mapper_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned DATA_OUT_WIDTH = 4,
  parameter int unsigned SPS            = 4,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [BYTE_WIDTH-1:0]     i_data_in,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  output logic [DATA_OUT_WIDTH-1:0] o_sym_out,
  output logic                      o_sym_valid,
  input  logic                      i_sym_ready,
  output logic                      o_busy
);

  localparam int unsigned BIT_CNT_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int unsigned SAMP_CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(BYTE_WIDTH - 1);
  localparam logic [SAMP_CNT_W-1:0] SAMP_LAST = SAMP_CNT_W'(SPS - 1);

  state_t                  state;
  logic [BYTE_WIDTH-1:0]   shreg;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [SAMP_CNT_W-1:0]   samp_cnt;

  logic last_bit;
  logic last_samp;
  logic sym_hs;
  logic load;
  logic cur_bit;

  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_samp = (samp_cnt == SAMP_LAST);
  assign sym_hs    = o_sym_valid & i_sym_ready;

  // Ready is held low during reset even though state already reads IDLE.
  assign o_data_ready = ~i_rst & ((state == IDLE) |
                                  ((state == SEND) & last_bit & last_samp & i_sym_ready));
  assign load = i_data_valid & o_data_ready;

  assign cur_bit     = MSB_FIRST ? shreg[BYTE_WIDTH-1] : shreg[0];
  assign o_sym_valid = (state == SEND);
  assign o_busy      = (state == SEND);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      samp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg    <= i_data_in;
            bit_cnt  <= '0;
            samp_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (sym_hs) begin
            if (!last_samp) begin
              samp_cnt <= samp_cnt + SAMP_CNT_W'(1);
            end else if (!last_bit) begin
              samp_cnt <= '0;
              bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
              shreg    <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            end else begin
              samp_cnt <= '0;
              bit_cnt  <= '0;
              if (load) begin
                shreg <= i_data_in;
                state <= SEND;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bpsk_bit_map #(
    .DATA_OUT_WIDTH(DATA_OUT_WIDTH)
  ) u_bit_map (
    .tx_bit (cur_bit),
    .valid  (o_sym_valid),
    .sym_out(o_sym_out)
  );

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// Directed and loopback bench for bpsk_symbol_mapper across three SPS/bit-order configurations.
module tb_bpsk_symbol_mapper;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] din    [3];
  logic       dvalid [3];
  logic       sready [3];
  logic [3:0] sym    [3];
  logic       svalid [3];
  logic       dready [3];
  logic       busy   [3];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // 0: SPS=1 MSB first, 1: SPS=4 LSB first, 2: SPS=2 MSB first
  bpsk_symbol_mapper #(.BYTE_WIDTH(8), .DATA_OUT_WIDTH(4), .SPS(1), .MSB_FIRST(1'b1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[0]), .i_data_valid(dvalid[0]),
    .o_data_ready(dready[0]), .o_sym_out(sym[0]), .o_sym_valid(svalid[0]),
    .i_sym_ready(sready[0]), .o_busy(busy[0]));

  bpsk_symbol_mapper #(.BYTE_WIDTH(8), .DATA_OUT_WIDTH(4), .SPS(4), .MSB_FIRST(1'b0)) dut_s4 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[1]), .i_data_valid(dvalid[1]),
    .o_data_ready(dready[1]), .o_sym_out(sym[1]), .o_sym_valid(svalid[1]),
    .i_sym_ready(sready[1]), .o_busy(busy[1]));

  bpsk_symbol_mapper #(.BYTE_WIDTH(8), .DATA_OUT_WIDTH(4), .SPS(2), .MSB_FIRST(1'b1)) dut_s2 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[2]), .i_data_valid(dvalid[2]),
    .o_data_ready(dready[2]), .o_sym_out(sym[2]), .o_sym_valid(svalid[2]),
    .i_sym_ready(sready[2]), .o_busy(busy[2]));

  typedef struct {
    int unsigned d;
    logic [7:0]  word;
    logic [7:0]  order;    // bits in transmit order, first-sent bit at [7]
    int unsigned sps;
    int          stall_at; // sample index to stall on for 3 cycles, -1 for none
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_sym(input logic b);
    return b ? 4'hF : 4'h1;
  endfunction

  task automatic run_word(input int unsigned d, input logic [7:0] word, input logic [7:0] order,
                          input int unsigned sps, input int stall_at, input string tag);
    int unsigned n_samp;
    logic [3:0]  e;
    n_samp = 8 * sps;
    @(negedge clk);
    check({tag, " idle ready"}, 16'(dready[d]), 16'd1);
    check({tag, " idle valid"}, 16'(svalid[d]), 16'd0);
    din[d] = word; dvalid[d] = 1'b1; sready[d] = 1'b1;
    @(posedge clk); #1;
    dvalid[d] = 1'b0; din[d] = ~word;
    for (int unsigned n = 0; n < n_samp; n++) begin
      e = exp_sym(order[7 - n / sps]);
      check($sformatf("%s sym[%0d]", tag, n), 16'(sym[d]), 16'(e));
      check($sformatf("%s valid[%0d]", tag, n), 16'(svalid[d]), 16'd1);
      check($sformatf("%s busy[%0d]", tag, n), 16'(busy[d]), 16'd1);
      check($sformatf("%s ready[%0d]", tag, n), 16'(dready[d]), 16'(n == n_samp - 1));
      if (int'(n) == stall_at) begin
        sready[d] = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check($sformatf("%s stall sym[%0d]", tag, n), 16'(sym[d]), 16'(e));
          check($sformatf("%s stall valid[%0d]", tag, n), 16'(svalid[d]), 16'd1);
          check($sformatf("%s stall ready[%0d]", tag, n), 16'(dready[d]), 16'd0);
        end
        sready[d] = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, " end valid"}, 16'(svalid[d]), 16'd0);
    check({tag, " end sym"}, 16'(sym[d]), 16'd0);
    check({tag, " end busy"}, 16'(busy[d]), 16'd0);
    check({tag, " end ready"}, 16'(dready[d]), 16'd1);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 8'b1010_0101, 1, -1};
    vecs[1] = '{1, 8'h01, 8'b1000_0000, 4, -1};
    vecs[2] = '{2, 8'h80, 8'b1000_0000, 2, 5};
    vecs[3] = '{1, 8'hC3, 8'b1100_0011, 4, -1};
    vecs[4] = '{0, 8'h3C, 8'b0011_1100, 1, -1};
    vecs[5] = '{2, 8'h96, 8'b1001_0110, 2, 0};
    vecs[6] = '{1, 8'h70, 8'b0000_1110, 4, -1};
    vecs[7] = '{2, 8'h3C, 8'b0011_1100, 2, 15};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; dvalid[i] = 1'b0; sready[i] = 1'b1;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset valid %0d", i), 16'(svalid[i]), 16'd0);
      check($sformatf("reset sym %0d", i), 16'(sym[i]), 16'd0);
      check($sformatf("reset busy %0d", i), 16'(busy[i]), 16'd0);
      check($sformatf("reset ready %0d", i), 16'(dready[i]), 16'd0);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_word(vecs[v].d, vecs[v].word, vecs[v].order, vecs[v].sps, vecs[v].stall_at,
               $sformatf("vec%0d", v));
    end

    // Back-to-back FF then 00 with valid held; data changes while not ready must be ignored.
    @(negedge clk);
    din[0] = 8'hFF; dvalid[0] = 1'b1; sready[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 8'h00;
    for (int n = 0; n < 16; n++) begin
      check($sformatf("b2b sym[%0d]", n), 16'(sym[0]), (n < 8) ? 16'hF : 16'h1);
      check($sformatf("b2b valid[%0d]", n), 16'(svalid[0]), 16'd1);
      check($sformatf("b2b ready[%0d]", n), 16'(dready[0]), 16'(n == 7 || n == 15));
      if (n == 15) dvalid[0] = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b end valid", 16'(svalid[0]), 16'd0);
    check("b2b end ready", 16'(dready[0]), 16'd1);

    // Asynchronous reset in the middle of 5A.
    @(negedge clk);
    din[0] = 8'h5A; dvalid[0] = 1'b1;
    @(posedge clk); #1;
    dvalid[0] = 1'b0;
    check("rstmid sym0", 16'(sym[0]), 16'h1);
    @(posedge clk); #1;
    check("rstmid sym1", 16'(sym[0]), 16'hF);
    @(posedge clk); #1;
    check("rstmid sym2", 16'(sym[0]), 16'h1);
    #1 rst = 1'b1;
    #1;
    check("rstmid valid", 16'(svalid[0]), 16'd0);
    check("rstmid sym", 16'(sym[0]), 16'd0);
    check("rstmid busy", 16'(busy[0]), 16'd0);
    check("rstmid ready", 16'(dready[0]), 16'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    run_word(0, 8'h00, 8'h00, 1, -1, "post-reset");

    // Loopback through a sign slicer with random downstream backpressure.
    for (int w = 0; w < 1000; w++) begin
      logic [7:0]  word;
      logic [15:0] got;
      logic [15:0] expw;
      int unsigned nh;
      int unsigned guard;
      word = 8'($urandom);
      guard = 0;
      while (!dready[2] && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      check($sformatf("loop%0d ready", w), 16'(dready[2]), 16'd1);
      din[2] = word; dvalid[2] = 1'b1;
      @(posedge clk); #1;
      dvalid[2] = 1'b0;
      nh = 0; got = '0; guard = 0;
      while (nh < 16 && guard < 200) begin
        sready[2] = ($urandom_range(3) != 0);
        if (svalid[2] && sready[2]) begin
          got = {got[14:0], sym[2][3]};
          nh++;
        end
        @(posedge clk); #1; guard++;
      end
      sready[2] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        expw[15 - 2 * k] = word[7 - k];
        expw[14 - 2 * k] = word[7 - k];
      end
      check($sformatf("loop%0d bits", w), got, expw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpsk_symbol_mapper.md
Name: bpsk_symbol_mapper

Overview:
- Transmit-side counterpart of the sign-decision rounder, which maps sample sign to ±1.0.
- Accepts parallel data words over a valid/ready handshake and serializes them bit by bit.
- Maps each bit to a two's-complement ±1.0 symbol and holds each symbol for SPS output samples, with output backpressure.
- Bit 0 maps to +1.0 and bit 1 maps to -1.0, so that slicing the output with the rounder (sign bit) recovers the original bit.

Parameters:
- BYTE_WIDTH, 8: bits per input word; must be >= 1.
- DATA_OUT_WIDTH, 4: symbol width, two's complement; must be >= 2.
- SPS, 4: output samples per bit (symbol repetition); must be >= 1.
- MSB_FIRST, 1: 1 = transmit bit BYTE_WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_data_in  input  BYTE_WIDTH  word to transmit
- i_data_valid  input  1  i_data_in is valid
- o_data_ready  output  1  block accepts a word this cycle
- o_sym_out  output  DATA_OUT_WIDTH  mapped symbol sample
- o_sym_valid  output  1  o_sym_out is valid
- i_sym_ready  input  1  downstream accepts a sample this cycle
- o_busy  output  1  a word is being serialized

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; shift register, bit_cnt and samp_cnt = 0.
  - o_sym_out=0, o_sym_valid=0, o_busy=0.
  - o_data_ready=0 while i_rst=1.
- Symbol mapping:
  - bit 0 -> +1.0 = value 1 (binary 0...01).
  - bit 1 -> -1.0 = all ones.
  - o_sym_out=0 whenever o_sym_valid=0.
- States:
  - IDLE: o_data_ready=1. On i_data_valid & o_data_ready, load the shift register, clear both counters, go to SEND.
  - SEND: o_sym_valid=1, o_busy=1. o_sym_out = map(current bit).
- Sample handshake (hs = o_sym_valid & i_sym_ready):
  - On hs: samp_cnt++.
  - When samp_cnt=SPS-1 on hs: samp_cnt=0, advance to the next bit, bit_cnt++.
  - Without hs, o_sym_out and o_sym_valid hold stable (no change under backpressure).
- Last sample: bit_cnt=BYTE_WIDTH-1 and samp_cnt=SPS-1.
  - o_data_ready = (state==IDLE) | (state==SEND & last sample & i_sym_ready). This is combinational from i_sym_ready and documented as such.
  - On hs at last sample with i_data_valid=1: load the new word and stay in SEND. The next cycle shows the first bit of the new word, giving zero-gap streaming.
  - On hs at last sample with i_data_valid=0: go to IDLE; o_sym_valid=0 the next cycle.
- Latency: word accepted at edge T -> first sample valid after edge T (cycle T+1).
- Word duration: exactly BYTE_WIDTH*SPS handshakes.
- i_data_in is ignored whenever o_data_ready=0.
- Reset mid-word: the word is discarded with no partial completion; outputs return to reset values immediately.
- SPS=1: every handshake advances one bit.
- BYTE_WIDTH=1: each word is one bit.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SEND);
  - function/constants for SYM_POS (value 1) and SYM_NEG (all ones) sized by DATA_OUT_WIDTH;
  - the bit->symbol mapping convention shared with the rounder so both ends agree.
- One sub-module, bpsk_bit_map: combinational bit + valid -> DATA_OUT_WIDTH symbol.
- Counters and the FSM stay in the top module.

Test Plan:
- SPS=1, MSB_FIRST=1, i_sym_ready=1, word 8'hA5 -> samples F,1,F,1,1,F,1,F on 8 consecutive cycles starting 1 cycle after accept; then o_sym_valid=0 and o_data_ready=1.
- SPS=4, MSB_FIRST=0, word 8'h01 -> 4 samples of F, then 28 samples of 1; o_busy high for exactly 32 handshakes.
- Backpressure: SPS=2, word 8'h80; drop i_sym_ready for 3 cycles mid-word -> o_sym_out/o_sym_valid frozen during the stall; total sample count still 16; sequence unchanged.
- Back-to-back: i_data_valid held with words 8'hFF then 8'h00, SPS=1 -> 8 samples of F immediately followed by 8 samples of 1 with no idle cycle; o_data_ready pulses only on the final sample of each word.
- Reset mid-word: assert i_rst asynchronously after 3 samples of 8'h5A -> o_sym_valid, o_sym_out and o_busy go to 0 without waiting for a clock edge; after release, new word 8'h00 -> clean 8 samples of 1.
- Loopback: feed o_sym_out through a rounder-style sign slicer on random words -> recovered bit stream equals transmitted bits for 1000 words.
